// File: rtl/ro_freq_monitor_pkg.sv
// Shared types for the ring-oscillator frequency monitor.
// FSM state encoding is fixed so that existing debug taps keep their meaning.
package ro_freq_monitor_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2,
        EVAL  = 2'd3
    } mon_state_e;

endpackage

// File: rtl/ro_freq_monitor_if.sv
// Configuration/result bundle of the RO frequency monitor.
// The master side configures and observes; the monitor is the slave.
interface ro_freq_monitor_if #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned WIN_W = 16
);
    logic             ro_in;
    logic             mon_en;
    logic [WIN_W-1:0] win_len;
    logic [CNT_W-1:0] thr_lo;
    logic [CNT_W-1:0] thr_hi;
    logic             alarm_clr;
    logic [CNT_W-1:0] cnt_out;
    logic             cnt_vld;
    logic             alarm_lo;
    logic             alarm_hi;
    logic             alarm_sticky;
    logic             busy;

    modport master (
        output ro_in, mon_en, win_len, thr_lo, thr_hi, alarm_clr,
        input  cnt_out, cnt_vld, alarm_lo, alarm_hi, alarm_sticky, busy
    );

    modport slave (
        input  ro_in, mon_en, win_len, thr_lo, thr_hi, alarm_clr,
        output cnt_out, cnt_vld, alarm_lo, alarm_hi, alarm_sticky, busy
    );
endinterface

// File: rtl/ro_freq_monitor_sync_edge.sv
// Synchronizer for the asynchronous RO output plus rising-edge detect.
// While flush_i is high the delayed copy keeps tracking, so no stale edge survives.
module ro_freq_monitor_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    input  logic flush_i,
    output logic edge_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_o = sync_q[SYNC_STAGES-1] & ~prev_q & ~flush_i;
endmodule

// File: rtl/ro_freq_monitor.sv
// Counts RO rising edges over a programmable mclk window and flags counts
// outside [thr_lo, thr_hi]; per-window alarms plus a sticky alarm.
module ro_freq_monitor
    import ro_freq_monitor_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned WIN_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                mclk,
    input  logic                puc_rst,
    ro_freq_monitor_if.slave    bus
);
    localparam int unsigned ARM_W = $clog2(SYNC_STAGES + 1);

    mon_state_e       state_q;
    logic [ARM_W-1:0] arm_q;
    logic [WIN_W-1:0] win_q;
    logic [WIN_W-1:0] tmr_q;
    logic [CNT_W-1:0] thr_lo_q;
    logic [CNT_W-1:0] thr_hi_q;
    logic [CNT_W-1:0] edge_cnt_q;
    logic [CNT_W-1:0] cnt_out_q;
    logic             vld_q;
    logic             lo_q;
    logic             hi_q;
    logic             sticky_q;
    logic             busy_q;

    logic             ro_edge;
    logic [WIN_W-1:0] win_len_eff;
    logic             lo_d;
    logic             hi_d;

    ro_freq_monitor_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
        .clk_i   (mclk),
        .rst_i   (puc_rst),
        .async_i (bus.ro_in),
        .flush_i (state_q == ARM),
        .edge_o  (ro_edge)
    );

    assign win_len_eff = (bus.win_len == '0) ? WIN_W'(1) : bus.win_len;
    assign lo_d        = edge_cnt_q < thr_lo_q;
    assign hi_d        = edge_cnt_q > thr_hi_q;

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state_q    <= IDLE;
            arm_q      <= '0;
            win_q      <= '0;
            tmr_q      <= '0;
            thr_lo_q   <= '0;
            thr_hi_q   <= '0;
            edge_cnt_q <= '0;
            cnt_out_q  <= '0;
            vld_q      <= 1'b0;
            lo_q       <= 1'b0;
            hi_q       <= 1'b0;
            sticky_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            // A fresh alarm beats a simultaneous clear request.
            if (state_q == EVAL && (lo_d || hi_d)) begin
                sticky_q <= 1'b1;
            end else if (bus.alarm_clr) begin
                sticky_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (bus.mon_en) begin
                        state_q <= ARM;
                        arm_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ARM: begin
                    if (!bus.mon_en) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (arm_q == ARM_W'(SYNC_STAGES)) begin
                        state_q    <= COUNT;
                        tmr_q      <= '0;
                        edge_cnt_q <= '0;
                        win_q      <= win_len_eff;
                        thr_lo_q   <= bus.thr_lo;
                        thr_hi_q   <= bus.thr_hi;
                    end else begin
                        arm_q <= arm_q + ARM_W'(1);
                    end
                end
                COUNT: begin
                    if (!bus.mon_en) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        edge_cnt_q <= '0;
                    end else begin
                        if (ro_edge && edge_cnt_q != '1) begin
                            edge_cnt_q <= edge_cnt_q + CNT_W'(1);
                        end
                        if (tmr_q == win_q - WIN_W'(1)) begin
                            state_q <= EVAL;
                        end else begin
                            tmr_q <= tmr_q + WIN_W'(1);
                        end
                    end
                end
                EVAL: begin
                    cnt_out_q  <= edge_cnt_q;
                    lo_q       <= lo_d;
                    hi_q       <= hi_d;
                    vld_q      <= 1'b1;
                    edge_cnt_q <= '0;
                    if (bus.mon_en) begin
                        state_q  <= COUNT;
                        tmr_q    <= '0;
                        win_q    <= win_len_eff;
                        thr_lo_q <= bus.thr_lo;
                        thr_hi_q <= bus.thr_hi;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.cnt_out      = cnt_out_q;
    assign bus.cnt_vld      = vld_q;
    assign bus.alarm_lo     = lo_q;
    assign bus.alarm_hi     = hi_q;
    assign bus.alarm_sticky = sticky_q;
    assign bus.busy         = busy_q;
endmodule
